// File: rtl/ring_divider_n.sv
// One-hot ring sequencer / divide-by-L with a runtime length, up/down direction,
// a registered terminal-count pulse and a binary count. All outputs come from registers.
module ring_divider_n #(
  parameter  int N  = 10,
  localparam int CW = $clog2(N),
  localparam int LW = $clog2(N + 1)
) (
  input  logic          cp0,
  input  logic          mr,
  input  logic          cp1,
  input  logic          dir,
  input  logic [LW-1:0] len,
  output logic [N-1:0]  out_q,
  output logic [CW-1:0] ctr_q,
  output logic          carry,
  output logic          tc
);

  localparam logic [LW-1:0] LEN_MAX = LW'(N);
  localparam logic [LW-1:0] LEN_MIN = LW'(2);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] l_act_q, l_act_d;
  logic          tc_q, tc_d;

  logic [LW-1:0] l_eff;
  logic [LW-1:0] cnt_ext;
  logic [LW:0]   half_len;
  logic          out_of_range;
  logic          terminal;

  // Out-of-range lengths fall back to the full ring.
  assign l_eff = ((len >= LEN_MIN) && (len <= LEN_MAX)) ? len : LEN_MAX;

  assign cnt_ext      = LW'(cnt_q);
  assign out_of_range = (cnt_ext >= l_act_q);
  // A corrupted count counts as terminal in both directions, so it recovers on one advance.
  assign terminal     = out_of_range ||
                        (dir ? (cnt_q == '0) : (cnt_ext == (l_act_q - LW'(1))));

  always_comb begin
    cnt_d   = cnt_q;
    l_act_d = l_act_q;
    tc_d    = 1'b0;
    if (mr) begin
      cnt_d   = '0;
      l_act_d = l_eff;
    end else if (!cp1) begin
      if (terminal) begin
        l_act_d = l_eff;
        tc_d    = 1'b1;
        cnt_d   = dir ? CW'(l_eff - LW'(1)) : '0;
      end else begin
        cnt_d = dir ? (cnt_q - CW'(1)) : (cnt_q + CW'(1));
      end
    end
  end

  always_ff @(posedge cp0) begin
    cnt_q   <= cnt_d;
    l_act_q <= l_act_d;
    tc_q    <= tc_d;
  end

  // carry is high for the first ceil(L_act/2) counts of the period.
  assign half_len = ({1'b0, l_act_q} + (LW+1)'(1)) >> 1;
  assign carry    = ({1'b0, cnt_ext} < half_len);

  always_comb begin
    out_q = '0;
    for (int i = 0; i < N; i++) begin
      out_q[i] = (cnt_q == CW'(i));
    end
  end

  assign ctr_q = cnt_q;
  assign tc    = tc_q;

endmodule

// File: tb/tb_ring_divider_n.sv
// Bench for ring_divider_n: a behavioural model pushes the expected output word each
// cycle; scenario tasks pop and compare it after the edge, plus spec-literal checks.
module tb_ring_divider_n;

  localparam int N  = 10;
  localparam int CW = $clog2(N);
  localparam int LW = $clog2(N + 1);
  localparam int W  = N + CW + 2;

  logic          cp0;
  logic          mr;
  logic          cp1;
  logic          dir;
  logic [LW-1:0] len;
  logic [N-1:0]  out_q;
  logic [CW-1:0] ctr_q;
  logic          carry;
  logic          tc;

  logic [W-1:0] exp_q[$];
  int n_cmp;
  int n_err;
  int m_cnt;
  int m_lact;
  int m_tc;

  ring_divider_n #(.N(N)) dut (
    .cp0  (cp0),
    .mr   (mr),
    .cp1  (cp1),
    .dir  (dir),
    .len  (len),
    .out_q(out_q),
    .ctr_q(ctr_q),
    .carry(carry),
    .tc   (tc)
  );

  // clock / reset block
  initial cp0 = 1'b0;
  always #5 cp0 = ~cp0;

  initial begin
    mr  = 1'b1;
    cp1 = 1'b0;
    dir = 1'b0;
    len = LW'(N);
  end

  function automatic logic [W-1:0] obs();
    return {out_q, ctr_q, carry, tc};
  endfunction

  // Driver: apply inputs, advance the model, push the expected word, clock once.
  task automatic step(input logic m, input logic h, input logic d, input int l);
    int leff;
    bit term;
    logic [N-1:0] oh;
    mr  = m;
    cp1 = h;
    dir = d;
    len = LW'(l);
    leff = (l >= 2 && l <= N) ? l : N;
    if (m) begin
      m_cnt = 0; m_lact = leff; m_tc = 0;
    end else if (h) begin
      m_tc = 0;
    end else begin
      term = (m_cnt >= m_lact) || (d ? (m_cnt == 0) : (m_cnt == m_lact - 1));
      if (term) begin
        m_lact = leff;
        m_cnt  = d ? leff - 1 : 0;
        m_tc   = 1;
      end else begin
        m_cnt = d ? m_cnt - 1 : m_cnt + 1;
        m_tc  = 0;
      end
    end
    oh = '0;
    oh[m_cnt] = 1'b1;
    exp_q.push_back({oh, CW'(m_cnt), (m_cnt < (m_lact + 1) / 2), m_tc[0]});
    @(posedge cp0);
    #1;
  endtask

  task automatic test_reset();
    logic [W-1:0] e;
    step(1, 1, 1, 10);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL reset_model: got %h exp %h", obs(), e); end
    n_cmp++;
    if ({out_q, ctr_q, carry, tc} !== {N'(1), CW'(0), 1'b1, 1'b0}) begin
      n_err++; $display("FAIL reset_literal: out=%b ctr=%0d carry=%b tc=%b", out_q, ctr_q, carry, tc);
    end
  endtask

  task automatic test_count_up();
    logic [W-1:0] e;
    int pulses;
    pulses = 0;
    step(1, 0, 0, 10);
    void'(exp_q.pop_front());
    for (int i = 0; i < 25; i++) begin
      step(0, 0, 0, 10);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs() !== e) begin n_err++; $display("FAIL up_model[%0d]: got %h exp %h", i, obs(), e); end
      n_cmp++;
      if (ctr_q !== CW'((i + 1) % 10)) begin
        n_err++; $display("FAIL up_ctr[%0d]: got %0d exp %0d", i, ctr_q, (i + 1) % 10);
      end
      if (tc === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 2) begin n_err++; $display("FAIL up_tc_pulses: got %0d exp 2", pulses); end
  endtask

  task automatic test_hold();
    logic [W-1:0] e;
    step(1, 0, 0, 10);
    void'(exp_q.pop_front());
    for (int i = 0; i < 3; i++) begin step(0, 0, 0, 10); void'(exp_q.pop_front()); end
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 10);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs() !== e || ctr_q !== CW'(3) || tc !== 1'b0) begin
        n_err++; $display("FAIL hold[%0d]: got %h exp %h", i, obs(), e);
      end
    end
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, 10);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs() !== e || ctr_q !== CW'(4 + i)) begin
        n_err++; $display("FAIL resume[%0d]: got %h exp %h", i, obs(), e);
      end
    end
    step(1, 1, 0, 10);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs() !== e || ctr_q !== CW'(0) || out_q !== N'(1)) begin
      n_err++; $display("FAIL hold_reset: got %h exp %h", obs(), e);
    end
  endtask

  task automatic test_len_change();
    logic [W-1:0] e;
    step(1, 0, 0, 10);
    void'(exp_q.pop_front());
    for (int i = 0; i < 2; i++) begin step(0, 0, 0, 10); void'(exp_q.pop_front()); end
    // len drops to 4 at count 2: current period still runs to 9.
    for (int i = 0; i < 15; i++) begin
      step(0, 0, 0, 4);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs() !== e) begin n_err++; $display("FAIL len_model[%0d]: got %h exp %h", i, obs(), e); end
      n_cmp++;
      if (ctr_q !== CW'((i < 7) ? i + 3 : (i - 7) % 4)) begin
        n_err++; $display("FAIL len_ctr[%0d]: got %0d exp %0d", i, ctr_q, (i < 7) ? i + 3 : (i - 7) % 4);
      end
      if (i >= 7) begin
        n_cmp++;
        if (carry !== (ctr_q < 2) || tc !== (ctr_q == 0)) begin
          n_err++; $display("FAIL len_carry_tc[%0d]: carry=%b tc=%b ctr=%0d", i, carry, tc, ctr_q);
        end
      end
    end
  endtask

  task automatic test_down();
    logic [W-1:0] e;
    int seq[10] = '{5, 4, 3, 2, 1, 0, 5, 4, 3, 4};
    step(1, 0, 1, 6);
    void'(exp_q.pop_front());
    for (int i = 0; i < 12; i++) begin
      step(0, 0, (i < 9) ? 1'b1 : 1'b0, 6);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs() !== e) begin n_err++; $display("FAIL down_model[%0d]: got %h exp %h", i, obs(), e); end
      if (i < 10) begin
        n_cmp++;
        if (ctr_q !== CW'(seq[i])) begin
          n_err++; $display("FAIL down_ctr[%0d]: got %0d exp %0d", i, ctr_q, seq[i]);
        end
      end
      n_cmp++;
      if (tc !== (i == 0 || i == 6 || i == 11)) begin
        n_err++; $display("FAIL down_tc[%0d]: got %b", i, tc);
      end
    end
  endtask

  task automatic test_clamp();
    logic [W-1:0] e;
    int lens[3] = '{0, 1, 15};
    foreach (lens[k]) begin
      step(1, 0, 0, lens[k]);
      void'(exp_q.pop_front());
      for (int i = 0; i < 11; i++) begin
        step(0, 0, 0, lens[k]);
        e = exp_q.pop_front();
        n_cmp++;
        if (obs() !== e || ctr_q !== CW'((i + 1) % 10)) begin
          n_err++; $display("FAIL clamp_len%0d[%0d]: got %h exp %h", lens[k], i, obs(), e);
        end
      end
    end
    step(1, 0, 0, 2);
    void'(exp_q.pop_front());
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 2);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs() !== e || ctr_q !== CW'((i + 1) % 2) || tc !== (i % 2 == 1)) begin
        n_err++; $display("FAIL clamp_len2[%0d]: got %h exp %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [W-1:0] e;
    step(1, 0, 0, 10);
    void'(exp_q.pop_front());
    for (int i = 0; i < 7; i++) begin step(0, 0, 0, 10); void'(exp_q.pop_front()); end
    step(1, 0, 1, 5);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs() !== e || ctr_q !== CW'(0) || tc !== 1'b0) begin
      n_err++; $display("FAIL mid_reset: got %h exp %h", obs(), e);
    end
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 5);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs() !== e || ctr_q !== CW'((i + 1) % 5)) begin
        n_err++; $display("FAIL mid_reset_seq[%0d]: got %h exp %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] e;
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 40) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 1) == 1), int'($urandom_range(0, 15)));
      e = exp_q.pop_front();
      n_cmp++;
      if (obs() !== e) begin n_err++; $display("FAIL random[%0d]: got %h exp %h", i, obs(), e); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    repeat (2) @(posedge cp0);
    #1;
    test_reset();
    test_count_up();
    test_hold();
    test_len_change();
    test_down();
    test_clamp();
    test_mid_reset();
    test_random();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL queue_drain: %0d entries left", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
